// File: rtl/fill_ctrl_pkg.sv
// Shared definitions for the fill controller: register map, CTRL/STATUS bit
// positions, line-measurement FSM states and the saturating counter helper.
package fill_ctrl_pkg;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_COLOR  = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_LINES  = 3'd3;
  localparam logic [2:0] ADDR_WIDTH  = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_APPLY   = 3;
  localparam int CTRL_IRQ_EN  = 8;

  localparam int STS_DONE  = 0;
  localparam int STS_SHORT = 1;
  localparam int STS_LONG  = 2;
  localparam int STS_MISS  = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_LINE   = 2'd2,
    S_HBLANK = 2'd3
  } meas_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fill_line_meas.sv
// Line/frame measurement: tracks blanking vs active lines and gathers per-frame
// line count, short-line count and min/max width, presenting the closing values.
module fill_line_meas
  import fill_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] H_DISP = 12'd1280
) (
  input  logic             pre_clk,
  input  logic             rst_n,
  input  logic             i_vsRise,
  input  logic             i_de,
  output logic             o_applyOk,
  output logic             o_frame,
  output logic             o_longSet,
  output logic [CNT_W-1:0] o_lineCnt,
  output logic [CNT_W-1:0] o_shortCnt,
  output logic [CNT_W-1:0] o_min,
  output logic [CNT_W-1:0] o_max
);

  meas_state_e      r_state;
  meas_state_e      w_stateNext;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_lineCnt;
  logic [CNT_W-1:0] r_shortCnt;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;
  logic             w_close;
  logic [CNT_W-1:0] w_closeWidth;
  logic [CNT_W-1:0] w_lineCnt;
  logic [CNT_W-1:0] w_shortCnt;
  logic [CNT_W-1:0] w_min;
  logic [CNT_W-1:0] w_max;

  // A frame sync rise always wins over the de-driven line transitions.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:             if (i_vsRise) w_stateNext = S_VBLANK;
      S_VBLANK, S_HBLANK: if (i_vsRise) w_stateNext = S_VBLANK;
                          else if (i_de) w_stateNext = S_LINE;
      S_LINE:             if (i_vsRise) w_stateNext = S_VBLANK;
                          else if (!i_de) w_stateNext = S_HBLANK;
      default:            w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    w_close      = (r_state == S_LINE) && (i_vsRise || !i_de);
    w_closeWidth = i_de ? sat_inc(r_width) : r_width;
    w_lineCnt    = r_lineCnt;
    w_shortCnt   = r_shortCnt;
    w_min        = r_min;
    w_max        = r_max;
    if (w_close) begin
      w_lineCnt = sat_inc(r_lineCnt);
      if (w_closeWidth < H_DISP) w_shortCnt = sat_inc(r_shortCnt);
      if (w_closeWidth < r_min)  w_min = w_closeWidth;
      if (w_closeWidth > r_max)  w_max = w_closeWidth;
    end
  end

  // Frame results include a line closed by the very sync rise that ends it.
  assign o_frame    = i_vsRise && (r_state != S_IDLE);
  assign o_longSet  = w_close && (w_closeWidth > H_DISP);
  assign o_lineCnt  = w_lineCnt;
  assign o_shortCnt = w_shortCnt;
  assign o_min      = (w_lineCnt == '0) ? '0 : w_min;
  assign o_max      = w_max;
  assign o_applyOk  = (r_state == S_IDLE) || (r_state == S_VBLANK);

  always_ff @(posedge pre_clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_width    <= '0;
      r_lineCnt  <= '0;
      r_shortCnt <= '0;
      r_min      <= CNT_MAX;
      r_max      <= '0;
    end else begin
      r_state <= w_stateNext;
      if ((r_state != S_LINE) && (w_stateNext == S_LINE))
        r_width <= CNT_W'(1);
      else if ((r_state == S_LINE) && i_de)
        r_width <= sat_inc(r_width);
      if (o_frame) begin
        r_lineCnt  <= '0;
        r_shortCnt <= '0;
        r_min      <= CNT_MAX;
        r_max      <= '0;
      end else begin
        r_lineCnt  <= w_lineCnt;
        r_shortCnt <= w_shortCnt;
        r_min      <= w_min;
        r_max      <= w_max;
      end
    end
  end

endmodule

// File: rtl/fill_ctrl.sv
// Video filler controller: shadowed CTRL/COLOR registers copied to the filler
// on frame sync or apply_now, plus frame statistics and a sticky STATUS/irq.
module fill_ctrl
  import fill_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] H_DISP = 12'd1280,
  parameter logic [CNT_W-1:0] V_DISP = 12'd720
) (
  input  logic        pre_clk,
  input  logic        rst_n,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic        pre_vs,
  input  logic        pre_de,
  output logic        fill_en,
  output logic [1:0]  fill_mode,
  output logic [23:0] fill_color,
  output logic        irq
);

  logic             r_vsDly;
  logic             w_vsRise;
  logic             r_en;
  logic             r_irqEn;
  logic [1:0]       r_mode;
  logic [23:0]      r_color;
  logic             w_enNext;
  logic             w_irqEnNext;
  logic [1:0]       w_modeNext;
  logic [23:0]      w_colorNext;
  logic             r_fillEn;
  logic [1:0]       r_fillMode;
  logic [23:0]      r_fillColor;
  logic [3:0]       r_status;
  logic [3:0]       w_statusSet;
  logic [3:0]       w_statusClr;
  logic [CNT_W-1:0] r_linesLine;
  logic [CNT_W-1:0] r_linesShort;
  logic [CNT_W-1:0] r_widthMin;
  logic [CNT_W-1:0] r_widthMax;
  logic [31:0]      r_rdata;
  logic [31:0]      w_rdataMux;
  logic             w_wrCtrl;
  logic             w_wrColor;
  logic             w_wrStatus;
  logic             w_apply;
  logic             w_applyOk;
  logic             w_frame;
  logic             w_longSet;
  logic [CNT_W-1:0] w_lineCnt;
  logic [CNT_W-1:0] w_shortCnt;
  logic [CNT_W-1:0] w_min;
  logic [CNT_W-1:0] w_max;
  logic             w_unusedWdata;

  assign w_vsRise      = pre_vs & ~r_vsDly;
  assign w_unusedWdata = ^reg_wdata[31:24];

  fill_line_meas #(.H_DISP(H_DISP)) u_meas (
    .pre_clk   (pre_clk),
    .rst_n     (rst_n),
    .i_vsRise  (w_vsRise),
    .i_de      (pre_de),
    .o_applyOk (w_applyOk),
    .o_frame   (w_frame),
    .o_longSet (w_longSet),
    .o_lineCnt (w_lineCnt),
    .o_shortCnt(w_shortCnt),
    .o_min     (w_min),
    .o_max     (w_max)
  );

  // The filler always receives the shadow values as updated by this cycle's write.
  always_comb begin
    w_wrCtrl    = reg_wr && (reg_addr == ADDR_CTRL);
    w_wrColor   = reg_wr && (reg_addr == ADDR_COLOR);
    w_wrStatus  = reg_wr && (reg_addr == ADDR_STATUS);
    w_enNext    = r_en;
    w_modeNext  = r_mode;
    w_irqEnNext = r_irqEn;
    w_colorNext = r_color;
    if (w_wrCtrl) begin
      w_enNext    = reg_wdata[CTRL_EN];
      w_modeNext  = reg_wdata[CTRL_MODE_HI:CTRL_MODE_LO];
      w_irqEnNext = reg_wdata[CTRL_IRQ_EN];
    end
    if (w_wrColor) w_colorNext = reg_wdata[23:0];
    w_apply = w_vsRise || (w_wrCtrl && reg_wdata[CTRL_APPLY] && w_applyOk);

    w_statusClr            = w_wrStatus ? reg_wdata[3:0] : 4'b0;
    w_statusSet            = 4'b0;
    w_statusSet[STS_DONE]  = w_frame;
    w_statusSet[STS_SHORT] = w_frame && (w_shortCnt != '0);
    w_statusSet[STS_LONG]  = w_longSet;
    w_statusSet[STS_MISS]  = w_frame && (w_lineCnt != V_DISP);

    w_rdataMux = 32'b0;
    case (reg_addr)
      ADDR_CTRL: begin
        w_rdataMux[CTRL_EN]                   = r_en;
        w_rdataMux[CTRL_MODE_HI:CTRL_MODE_LO] = r_mode;
        w_rdataMux[CTRL_IRQ_EN]               = r_irqEn;
      end
      ADDR_COLOR:  w_rdataMux = {8'b0, r_color};
      ADDR_STATUS: w_rdataMux = {28'b0, r_status};
      ADDR_LINES:  w_rdataMux = {4'b0, r_linesShort, 4'b0, r_linesLine};
      ADDR_WIDTH:  w_rdataMux = {4'b0, r_widthMax, 4'b0, r_widthMin};
      default:     w_rdataMux = 32'b0;
    endcase
  end

  always_ff @(posedge pre_clk) begin
    if (!rst_n) begin
      r_vsDly      <= 1'b0;
      r_en         <= 1'b0;
      r_mode       <= 2'b0;
      r_irqEn      <= 1'b0;
      r_color      <= 24'b0;
      r_fillEn     <= 1'b0;
      r_fillMode   <= 2'b0;
      r_fillColor  <= 24'b0;
      r_status     <= 4'b0;
      r_linesLine  <= '0;
      r_linesShort <= '0;
      r_widthMin   <= '0;
      r_widthMax   <= '0;
      r_rdata      <= 32'b0;
    end else begin
      r_vsDly <= pre_vs;
      r_en    <= w_enNext;
      r_mode  <= w_modeNext;
      r_irqEn <= w_irqEnNext;
      r_color <= w_colorNext;
      if (w_apply) begin
        r_fillEn    <= w_enNext;
        r_fillMode  <= w_modeNext;
        r_fillColor <= w_colorNext;
      end
      r_status <= (r_status & ~w_statusClr) | w_statusSet;
      if (w_frame) begin
        r_linesLine  <= w_lineCnt;
        r_linesShort <= w_shortCnt;
        r_widthMin   <= w_min;
        r_widthMax   <= w_max;
      end
      if (reg_rd) r_rdata <= w_rdataMux;
    end
  end

  assign reg_rdata  = r_rdata;
  assign fill_en    = r_fillEn;
  assign fill_mode  = r_fillMode;
  assign fill_color = r_fillColor;
  assign irq        = r_status[STS_DONE] & r_irqEn;

endmodule

// File: tb/tb_fill_ctrl.sv
// Self-checking bench for fill_ctrl: a frame/line-level reference model compared
// every cycle, directed frames with literal expectations, then random traffic.
module tb_fill_ctrl;

  localparam logic [11:0] H = 12'd8;
  localparam logic [11:0] V = 12'd4;

  logic        pre_clk = 1'b0;
  logic        rst_n;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        pre_vs;
  logic        pre_de;
  logic        fill_en;
  logic [1:0]  fill_mode;
  logic [23:0] fill_color;
  logic        irq;

  int checks = 0;
  int failures = 0;

  fill_ctrl #(.H_DISP(H), .V_DISP(V)) dut (
    .pre_clk   (pre_clk),
    .rst_n     (rst_n),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .pre_vs    (pre_vs),
    .pre_de    (pre_de),
    .fill_en   (fill_en),
    .fill_mode (fill_mode),
    .fill_color(fill_color),
    .irq       (irq)
  );

  always #5 pre_clk = ~pre_clk;

  // Reference model: lines are runs of de cycles after the first sync rise.
  bit          mValid = 1'b0;
  logic        mVsPrev, mStarted, mLineSinceVs;
  int          mRun;
  int          mWidths[$];
  logic        mEn, mIrqEn, mFillEn;
  logic [1:0]  mMode, mFillMode;
  logic [23:0] mColor, mFillColor;
  logic [3:0]  mStatus, tSet, tClr;
  logic [11:0] mLines, mShort, mMin, mMax;
  logic [31:0] mRdata;
  logic        tRise, tClosing, tApplyOk, tWrCtrl;
  int          tCloseW, tLines, tShort, tMin, tMax;

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    case (a)
      3'd0:    return {23'b0, mIrqEn, 5'b0, mMode, mEn};
      3'd1:    return {8'b0, mColor};
      3'd2:    return {28'b0, mStatus};
      3'd3:    return {4'b0, mShort, 4'b0, mLines};
      3'd4:    return {4'b0, mMax, 4'b0, mMin};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge pre_clk) begin
    if (!rst_n) begin
      mValid = 1'b1; mVsPrev = 1'b0; mStarted = 1'b0; mLineSinceVs = 1'b0; mRun = 0;
      mWidths.delete();
      mEn = 0; mIrqEn = 0; mMode = 0; mColor = 0;
      mFillEn = 0; mFillMode = 0; mFillColor = 0;
      mStatus = 0; mLines = 0; mShort = 0; mMin = 0; mMax = 0; mRdata = 0;
    end else begin
      tRise = pre_vs && !mVsPrev;
      if (reg_rd) mRdata = modelRead(reg_addr);
      tWrCtrl = reg_wr && (reg_addr == 3'd0);
      tApplyOk = !mStarted || (mRun == 0 && !mLineSinceVs);
      if (tWrCtrl) begin mEn = reg_wdata[0]; mMode = reg_wdata[2:1]; mIrqEn = reg_wdata[8]; end
      if (reg_wr && reg_addr == 3'd1) mColor = reg_wdata[23:0];
      if (tRise || (tWrCtrl && reg_wdata[3] && tApplyOk)) begin
        mFillEn = mEn; mFillMode = mMode; mFillColor = mColor;
      end
      tClr = (reg_wr && reg_addr == 3'd2) ? reg_wdata[3:0] : 4'b0;
      tSet = 4'b0;
      if (mStarted) begin
        tClosing = 1'b0;
        tCloseW = 0;
        if (tRise) begin
          if (mRun > 0) begin
            tClosing = 1'b1;
            tCloseW = (mRun + (pre_de ? 1 : 0) > 4095) ? 4095 : mRun + (pre_de ? 1 : 0);
          end
        end else if (pre_de) begin
          if (mRun == 0) mLineSinceVs = 1'b1;
          mRun = (mRun >= 4095) ? 4095 : mRun + 1;
        end else if (mRun > 0) begin
          tClosing = 1'b1;
          tCloseW = mRun;
        end
        if (tClosing) begin
          mRun = 0;
          mWidths.push_back(tCloseW);
          if (tCloseW > int'(H)) tSet[2] = 1'b1;
        end
        if (tRise) begin
          tLines = (mWidths.size() > 4095) ? 4095 : mWidths.size();
          tShort = 0; tMin = 0; tMax = 0;
          foreach (mWidths[k]) begin
            if (mWidths[k] < int'(H)) tShort++;
            if (k == 0 || mWidths[k] < tMin) tMin = mWidths[k];
            if (k == 0 || mWidths[k] > tMax) tMax = mWidths[k];
          end
          mLines = 12'(tLines); mShort = 12'(tShort); mMin = 12'(tMin); mMax = 12'(tMax);
          tSet[0] = 1'b1;
          if (tShort > 0) tSet[1] = 1'b1;
          if (tLines != int'(V)) tSet[3] = 1'b1;
          mWidths.delete();
          mRun = 0;
          mLineSinceVs = 1'b0;
        end
      end else if (tRise) begin
        mStarted = 1'b1;
        mLineSinceVs = 1'b0;
      end
      mStatus = (mStatus & ~tClr) | tSet;
      mVsPrev = pre_vs;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pre_clk) begin
    if (mValid) begin
      checkOutput("fill_en", 32'(fill_en), 32'(mFillEn));
      checkOutput("fill_mode", 32'(fill_mode), 32'(mFillMode));
      checkOutput("fill_color", 32'(fill_color), 32'(mFillColor));
      checkOutput("irq", 32'(irq), 32'(mStatus[0] & mIrqEn));
      checkOutput("reg_rdata", reg_rdata, mRdata);
    end
  end

  task automatic cycle();
    @(posedge pre_clk);
    #1;
    reg_wr = 1'b0;
    reg_rd = 1'b0;
  endtask

  task automatic applyStimulus(input logic vs, input logic de);
    pre_vs = vs;
    pre_de = de;
    cycle();
  endtask

  task automatic regWrite(input logic [2:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    cycle();
  endtask

  task automatic readCheck(input string name, input logic [2:0] a, input logic [31:0] exp);
    reg_rd = 1'b1; reg_addr = a;
    cycle();
    checkOutput(name, reg_rdata, exp);
  endtask

  task automatic sendLine(input int w);
    for (int i = 0; i < w; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic vsPulse();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic randStep(input logic vs, input logic de);
    pre_vs = vs;
    pre_de = de;
    if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
    reg_addr = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 4) == 0) begin
      reg_wr = 1'b1;
      reg_wdata = $urandom;
    end
    if ($urandom_range(0, 3) == 0) reg_rd = 1'b1;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pre_vs = 1'b0; pre_de = 1'b0;
    reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 3'd0; reg_wdata = 32'h0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    checkOutput("rst_fill_en", 32'(fill_en), 32'h0);
    checkOutput("rst_fill_color", 32'(fill_color), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    readCheck("rst_status", 3'd2, 32'h0);
    readCheck("rst_width", 3'd4, 32'h0);

    vsPulse();
    readCheck("first_vs_status", 3'd2, 32'h0);
    sendLine(8);
    regWrite(3'd0, 32'h107);
    regWrite(3'd1, 32'h123456);
    checkOutput("deferred_en", 32'(fill_en), 32'h0);
    checkOutput("deferred_color", 32'(fill_color), 32'h0);
    readCheck("ctrl_readback", 3'd0, 32'h107);
    repeat (3) sendLine(8);
    vsPulse();
    checkOutput("vs_fill_en", 32'(fill_en), 32'h1);
    checkOutput("vs_fill_mode", 32'(fill_mode), 32'h3);
    checkOutput("vs_fill_color", 32'(fill_color), 32'h123456);
    checkOutput("frame_irq", 32'(irq), 32'h1);
    checkOutput("model_lines", 32'(mLines), 32'h4);
    readCheck("full_lines", 3'd3, 32'h00000004);
    readCheck("full_width", 3'd4, 32'h00080008);
    readCheck("full_status", 3'd2, 32'h00000001);

    regWrite(3'd2, 32'hF);
    sendLine(8); sendLine(5); sendLine(8); sendLine(9);
    vsPulse();
    readCheck("mixed_status", 3'd2, 32'h00000007);
    readCheck("mixed_lines", 3'd3, 32'h00010004);
    readCheck("mixed_width", 3'd4, 32'h00090005);
    checkOutput("model_min", 32'(mMin), 32'h5);

    regWrite(3'd2, 32'hF);
    sendLine(8); sendLine(8);
    repeat (5) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    readCheck("cut_status", 3'd2, 32'h0000000B);
    readCheck("cut_lines", 3'd3, 32'h00010003);
    readCheck("cut_width", 3'd4, 32'h00080006);

    regWrite(3'd2, 32'hF);
    vsPulse();
    readCheck("empty_status", 3'd2, 32'h00000009);
    readCheck("empty_lines", 3'd3, 32'h0);
    readCheck("empty_width", 3'd4, 32'h0);

    regWrite(3'd1, 32'hABCDEF);
    regWrite(3'd0, 32'h10B);
    checkOutput("apply_mode", 32'(fill_mode), 32'h1);
    checkOutput("apply_color", 32'(fill_color), 32'hABCDEF);
    readCheck("apply_ctrl_rb", 3'd0, 32'h103);
    applyStimulus(1'b0, 1'b1);
    regWrite(3'd0, 32'h10F);
    checkOutput("apply_in_line_mode", 32'(fill_mode), 32'h1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    vsPulse();
    checkOutput("apply_after_vs_mode", 32'(fill_mode), 32'h3);

    regWrite(3'd2, 32'hF);
    repeat (4) sendLine(8);
    pre_vs = 1'b1;
    regWrite(3'd2, 32'h1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    readCheck("setwins_status", 3'd2, 32'h1);
    checkOutput("setwins_irq", 32'(irq), 32'h1);
    regWrite(3'd2, 32'h1);
    readCheck("w1c_status", 3'd2, 32'h0);
    checkOutput("w1c_irq", 32'(irq), 32'h0);

    repeat (3) applyStimulus(1'b0, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1);
    rst_n = 1'b1;
    checkOutput("midrst_fill_en", 32'(fill_en), 32'h0);
    checkOutput("midrst_fill_mode", 32'(fill_mode), 32'h0);
    checkOutput("midrst_fill_color", 32'(fill_color), 32'h0);
    checkOutput("midrst_irq", 32'(irq), 32'h0);
    applyStimulus(1'b0, 1'b0);
    vsPulse();
    readCheck("midrst_first_vs", 3'd2, 32'h0);
    repeat (4) sendLine(8);
    vsPulse();
    readCheck("midrst_second_vs", 3'd2, 32'h1);

    for (int f = 0; f < 60; f++) begin
      int nl;
      nl = $urandom_range(0, 5);
      randStep(1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) randStep(1'b1, 1'b0);
      randStep(1'b0, 1'b0);
      for (int l = 0; l < nl; l++) begin
        int w;
        w = $urandom_range(1, 11);
        for (int i = 0; i < w; i++) randStep(1'b0, 1'b1);
        if ($urandom_range(0, 9) == 0) randStep(1'b1, 1'b1);
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) randStep(1'b0, 1'b0);
      end
    end
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
